// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register responder: FSM states, command-field
// layout and default register-file geometry.
package spi_pkg;

    localparam int unsigned DEF_ADDR_W   = 5;
    localparam int unsigned DEF_DATA_W   = 24;
    localparam int unsigned CMD_W        = 8;
    localparam int unsigned CMD_RW_BIT   = 7;
    localparam int unsigned CMD_ADDR_MSB = 4;
    localparam int unsigned CMD_ADDR_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_DONE
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall pulses
// derived in the clk domain. Resets to the line's idle level.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        IDLE_LVL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{IDLE_LVL}};
            prev_q <= IDLE_LVL;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-0 slave fronting a 2**ADDR_W x DATA_W register file with a local read port.
// Optional burst auto-increment is enabled by defining SPI_RESP_AUTOINC_EN.
module spi_reg_responder
    import spi_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              csn,
    input  logic              si,
    output logic              so,
    output logic              so_oe,
    input  logic [ADDR_W-1:0] host_addr,
    output logic [DATA_W-1:0] host_rdata,
    output logic              wr_pulse,
    output logic              frame_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = (DATA_W + 1 > CMD_W) ? $clog2(DATA_W + 1) : $clog2(CMD_W);

    logic sck_s, sck_rise, sck_fall;
    logic csn_s, csn_rise, csn_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_sck_sync (
        .clk(clk), .rst(rst), .async_i(sck),
        .level_o(sck_s), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_csn_sync (
        .clk(clk), .rst(rst), .async_i(csn),
        .level_o(csn_s), .rise_o(csn_rise), .fall_o(csn_fall)
    );

    logic [SYNC_STAGES-1:0] si_sync_q, si_sync_d;
    logic                   si_s;
    logic [SYNC_STAGES:0]   settle_q, settle_d;
    logic                   settled;

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [CMD_W-2:0]  cmd_q, cmd_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] load_addr;
    logic              rd_q, rd_d;
    logic              so_q, so_d;
    logic              load_q, load_d;
    logic              commit_q, commit_d;
    logic              ferr_q, ferr_d;
    logic              armed_q, armed_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] host_rdata_q;

    assign si_s    = si_sync_q[SYNC_STAGES-1];
    assign settled = settle_q[SYNC_STAGES];
    // After reset, frames start only once csn has been seen high with the
    // synchronizers flushed, so a frame cut by rst is ignored until csn rises.
    assign armed_d = armed_q | (settled & csn_s);
    assign load_addr = (state_q == ST_DONE) ? addr_q + ADDR_W'(1) : addr_q;

    always_comb begin
        si_sync_d = {si_sync_q[SYNC_STAGES-2:0], si};
        settle_d  = {settle_q[SYNC_STAGES-1:0], 1'b1};
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        cmd_d     = cmd_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        addr_d    = addr_q;
        rd_d      = rd_q;
        so_d      = so_q;
        load_d    = 1'b0;
        commit_d  = 1'b0;
        ferr_d    = 1'b0;

        if (load_q) begin
            tx_d = mem_q[load_addr];
        end

        case (state_q)
            ST_IDLE: begin
                so_d = 1'b0;
                if (csn_fall && armed_q) begin
                    state_d  = ST_CMD;
                    bitcnt_d = '0;
                end
            end
            ST_CMD: begin
                so_d = 1'b0;
                if (csn_rise) begin
                    state_d = ST_IDLE;
                    ferr_d  = 1'b1;
                end else if (sck_rise) begin
                    cmd_d = {cmd_q[CMD_W-3:0], si_s};
                    if (bitcnt_q == CNT_W'(CMD_W - 1)) begin
                        state_d  = ST_DATA;
                        bitcnt_d = '0;
                        addr_d   = ADDR_W'({cmd_q[CMD_ADDR_MSB-1:CMD_ADDR_LSB], si_s});
                        rd_d     = cmd_q[CMD_RW_BIT-1];
                        load_d   = cmd_q[CMD_RW_BIT-1];
                    end else begin
                        bitcnt_d = bitcnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (csn_rise) begin
                    state_d = ST_IDLE;
                    ferr_d  = 1'b1;
                    so_d    = 1'b0;
                end else begin
                    if (sck_fall && rd_q) begin
                        so_d = tx_q[DATA_W-1];
                        tx_d = tx_q << 1;
                    end
                    if (sck_rise) begin
                        rx_d = {rx_q[DATA_W-2:0], si_s};
                        if (bitcnt_q == CNT_W'(DATA_W - 1)) begin
                            state_d  = ST_DONE;
                            bitcnt_d = '0;
                            commit_d = ~rd_q;
`ifdef SPI_RESP_AUTOINC_EN
                            load_d   = rd_q;
`endif
                        end else begin
                            bitcnt_d = bitcnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            ST_DONE: begin
                if (csn_rise) begin
                    state_d = ST_IDLE;
                    so_d    = 1'b0;
                end else begin
`ifdef SPI_RESP_AUTOINC_EN
                    // The next word's MSB goes out on the fall that follows the
                    // last rise, so the read path keeps shifting while in DONE.
                    if (sck_fall && rd_q) begin
                        so_d = tx_q[DATA_W-1];
                        tx_d = tx_q << 1;
                    end
                    if (sck_rise) begin
                        state_d  = ST_DATA;
                        addr_d   = addr_q + ADDR_W'(1);
                        rx_d     = {rx_q[DATA_W-2:0], si_s};
                        bitcnt_d = CNT_W'(1);
                    end
`else
                    so_d = 1'b0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            si_sync_q <= '0;
            settle_q  <= '0;
            state_q   <= ST_IDLE;
            bitcnt_q  <= '0;
            cmd_q     <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            addr_q    <= '0;
            rd_q      <= 1'b0;
            so_q      <= 1'b0;
            load_q    <= 1'b0;
            commit_q  <= 1'b0;
            ferr_q    <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            si_sync_q <= si_sync_d;
            settle_q  <= settle_d;
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            cmd_q     <= cmd_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            addr_q    <= addr_d;
            rd_q      <= rd_d;
            so_q      <= so_d;
            load_q    <= load_d;
            commit_q  <= commit_d;
            ferr_q    <= ferr_d;
            armed_q   <= armed_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            host_rdata_q <= '0;
        end else begin
            if (commit_q) begin
                mem_q[addr_q] <= rx_q;
            end
            host_rdata_q <= mem_q[host_addr];
        end
    end

    assign so         = so_q;
    assign so_oe      = armed_q & ~csn_s;
    assign wr_pulse   = commit_q;
    assign frame_err  = ferr_q;
    assign host_rdata = host_rdata_q;

endmodule

// File: doc/spi_reg_responder.md
SPI_REG_RESPONDER -- requirements
Module: spi_reg_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register address width (32 entries).
REQ-002 SHALL have parameter DATA_W, default 24, register and data-word width.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for sck, csn and si.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port sck  input  1  SPI clock from master, asynchronous to clk.
REQ-007 SHALL have port csn  input  1  SPI chip select, active low.
REQ-008 SHALL have port si  input  1  serial data in (MOSI).
REQ-009 SHALL have port so  output  1  serial data out (MISO).
REQ-010 SHALL have port so_oe  output  1  MISO output enable; high only while csn is low.
REQ-011 SHALL have port host_addr  input  ADDR_W  local read address into the register file.
REQ-012 SHALL have port host_rdata  output  DATA_W  register contents at host_addr, 1-cycle latency.
REQ-013 SHALL have port wr_pulse  output  1  one-cycle pulse on each committed SPI write.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse when csn rises mid-frame.

Function
REQ-015 SHALL sample sck/csn/si through SYNC_STAGES flops and use clk-domain edge detection; sck period SHALL be at least 8 clk periods.
REQ-016 SHALL implement SPI mode 0: si sampled on sck rising edge, so updated on sck falling edge, MSB first.
REQ-017 SHALL use a frame of 8-bit command then DATA_W data bits; command bit7 = read (1) / write (0), bits6:5 ignored, bits4:0 = address.
REQ-018 SHALL use states IDLE, CMD, DATA, DONE: IDLE->CMD on csn falling edge; CMD->DATA after 8th sck rise; DATA->DONE after DATA_W-th sck rise; DONE->IDLE on csn rising edge.
REQ-019 On a read, SHALL load regfile[addr] into the TX shift register in the clk cycle after the 8th sck rise, so that the MSB drives so at the following sck fall.
REQ-020 On a write, SHALL commit the received word to regfile[addr] and pulse wr_pulse in the clk cycle after the DATA_W-th sck rise.
REQ-021 SHALL drive so = 0 outside DATA of a read frame; so_oe = 1 whenever synchronized csn is low.
REQ-022 SHALL ignore sck edges in DONE (without burst); so = 0 there.
REQ-023 On csn rising in CMD or DATA, SHALL abort with no regfile write, pulse frame_err, return to IDLE.
REQ-024 SHALL ignore sck edges while csn is high.
REQ-025 Same-cycle SPI commit and host read of the same address SHALL return the old value; the new value appears one cycle later.

Reset
REQ-026 On rst: state IDLE, bit counter 0, shift registers 0, so 0, so_oe 0, wr_pulse 0, frame_err 0, host_rdata 0, synchronizers at idle levels (csn 1, sck 0).
REQ-027 Every regfile entry SHALL reset to 0.
REQ-028 rst mid-frame SHALL discard the frame without committing it; the remainder of the frame until csn rises SHALL be ignored.

Configuration
REQ-029 With SPI_RESP_AUTOINC_EN defined, when csn stays low after a frame, SHALL return from DONE to DATA with address+1 (wraps 31->0) for another DATA_W-bit word of the same direction.
REQ-030 Without SPI_RESP_AUTOINC_EN, SHALL hold DONE until csn rises, ignoring any extra bits.

Structure
REQ-031 Shared package spi_pkg SHALL hold the state enum, command-field bit positions, and default ADDR_W/DATA_W constants.
REQ-032 The synchronizer + edge detector SHALL be sub-module spi_sync_edge, instantiated for sck and csn; si uses the sync only.

Verification
REQ-033 Write cmd 0x05, data 0xABCDEF -> wr_pulse once; host_addr=5 gives 0xABCDEF next cycle.
REQ-034 After REQ-033, read cmd 0x85 -> so shifts 0xABCDEF MSB first; so_oe high for the whole frame; no wr_pulse.
REQ-035 Write cmd 0x03, csn rises after 12 data bits -> frame_err pulse, regfile[3] stays 0, next full frame works.
REQ-036 rst asserted during data bit 10 of a write to addr 7 -> regfile[7] = 0, all outputs at reset values.
REQ-037 With SPI_RESP_AUTOINC_EN: write cmd 0x1F, words 0x111111, 0x222222 -> regfile[31]=0x111111, regfile[0]=0x222222, two wr_pulses; without it -> only regfile[31] written.
